// File: rtl/perf_mon_pkg.sv
// Shared types for the AXI performance monitor: statistic indices, counter type,
// default snooped AXI request/response structs and the saturating adder.
package perf_mon_pkg;

  localparam int unsigned MaxCntWidth = 64;

  typedef logic [MaxCntWidth-1:0] cnt_t;

  typedef enum int unsigned {
    STAT_AW     = 0,
    STAT_AR     = 1,
    STAT_W      = 2,
    STAT_R      = 3,
    STAT_WBYTES = 4,
    STAT_RBYTES = 5,
    STAT_WLAT   = 6,
    STAT_RLAT   = 7,
    NUM_STATS   = 8
  } stat_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } mon_ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } mon_w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } mon_b_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } mon_r_chan_t;

  typedef struct packed {
    mon_ax_chan_t aw;
    logic         aw_valid;
    mon_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    mon_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } mon_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    mon_b_chan_t b;
    logic        b_valid;
    logic        ar_ready;
    mon_r_chan_t r;
    logic        r_valid;
  } mon_resp_t;

  typedef struct packed {
    logic sat;
    cnt_t val;
  } sat_res_t;

  // a + b clamped to max; sat reports that clamping happened
  function automatic sat_res_t sat_add(input cnt_t a, input cnt_t b, input cnt_t max);
    logic [MaxCntWidth:0] sum;
    sat_res_t             res;
    sum     = {1'b0, a} + {1'b0, b};
    res.sat = (sum > {1'b0, max});
    res.val = res.sat ? max : sum[MaxCntWidth-1:0];
    return res;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating statistic accumulator; exposes the post-add value of this cycle so the
// parent can capture it into a snapshot on the same edge the live count restarts.
module perf_sat_counter
  import perf_mon_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             load_zero_i,
  input  logic [Width-1:0] amount_i,
  output logic [Width-1:0] sum_c,
  output logic             sat_c
);

  logic [Width-1:0] cnt_d, cnt_q;
  sat_res_t         add_res;
  logic             unused_hi;

  always_comb begin
    add_res = sat_add(cnt_t'(cnt_q), cnt_t'(amount_i), cnt_t'({Width{1'b1}}));
    sum_c   = cnt_q;
    sat_c   = 1'b0;
    if (en_i) begin
      sum_c = Width'(add_res.val);
      sat_c = add_res.sat;
    end
    cnt_d = cnt_q;
    if (clear_i || load_zero_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = sum_c;
    end
  end

  // upper bits of the wide adder result are zero by construction
  assign unused_hi = ^add_res.val;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_perf_mon.sv
// Passive AXI4 performance monitor: handshake decode, outstanding-depth tracking,
// saturating statistics and fixed-window snapshotting of one snooped master port.
module axi_perf_mon
  import perf_mon_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned CntWidth     = 32,
  parameter int unsigned OutstWidth   = 5,
  parameter type         axi_req_t    = perf_mon_pkg::mon_req_t,
  parameter type         axi_resp_t   = perf_mon_pkg::mon_resp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [CntWidth-1:0]   window_i,
  input  axi_req_t              axi_req_i,
  input  axi_resp_t             axi_resp_i,
  output logic [CntWidth-1:0]   aw_cnt_o,
  output logic [CntWidth-1:0]   ar_cnt_o,
  output logic [CntWidth-1:0]   w_beats_o,
  output logic [CntWidth-1:0]   r_beats_o,
  output logic [CntWidth-1:0]   wr_bytes_o,
  output logic [CntWidth-1:0]   rd_bytes_o,
  output logic [CntWidth-1:0]   wr_lat_sum_o,
  output logic [CntWidth-1:0]   rd_lat_sum_o,
  output logic [OutstWidth-1:0] wr_outst_o,
  output logic [OutstWidth-1:0] rd_outst_o,
  output logic                  snap_valid_o,
  output logic                  overflow_o,
  output logic                  proto_err_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned NumStats  = NUM_STATS;
  localparam logic [OutstWidth-1:0] OutstMax = '1;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs;
  logic unused_bits;

  assign aw_hs     = axi_req_i.aw_valid & axi_resp_i.aw_ready;
  assign w_hs      = axi_req_i.w_valid & axi_resp_i.w_ready;
  assign b_hs      = axi_resp_i.b_valid & axi_req_i.b_ready;
  assign ar_hs     = axi_req_i.ar_valid & axi_resp_i.ar_ready;
  assign r_hs      = axi_resp_i.r_valid & axi_req_i.r_ready;
  assign r_last_hs = r_hs & axi_resp_i.r.last;

  // addresses, data and responses are snooped but never inspected
  assign unused_bits = ^{axi_req_i, axi_resp_i, 32'(AxiAddrWidth)};

  logic [OutstWidth-1:0] wr_outst_d, wr_outst_q, rd_outst_d, rd_outst_q;
  logic                  wr_err, rd_err;

  // Outstanding depth: simultaneous issue and retire cancel out
  always_comb begin
    wr_outst_d = wr_outst_q;
    rd_outst_d = rd_outst_q;
    wr_err     = 1'b0;
    rd_err     = 1'b0;
    if (aw_hs && !b_hs) begin
      if (wr_outst_q == OutstMax) wr_err = 1'b1;
      else                        wr_outst_d = wr_outst_q + OutstWidth'(1);
    end else if (b_hs && !aw_hs) begin
      if (wr_outst_q == '0) wr_err = 1'b1;
      else                  wr_outst_d = wr_outst_q - OutstWidth'(1);
    end
    if (ar_hs && !r_last_hs) begin
      if (rd_outst_q == OutstMax) rd_err = 1'b1;
      else                        rd_outst_d = rd_outst_q + OutstWidth'(1);
    end else if (r_last_hs && !ar_hs) begin
      if (rd_outst_q == '0) rd_err = 1'b1;
      else                  rd_outst_d = rd_outst_q - OutstWidth'(1);
    end
  end

  logic [CntWidth-1:0] win_len_q, win_cnt_d, win_cnt_q;
  logic                free_run, snap;

  // Window length is registered, so a new value takes effect one cycle later
  always_comb begin
    free_run  = (win_len_q == '0);
    snap      = en_i && !clear_i && !free_run && (win_cnt_q >= win_len_q - CntWidth'(1));
    win_cnt_d = win_cnt_q;
    if (clear_i || free_run) begin
      win_cnt_d = '0;
    end else if (en_i) begin
      win_cnt_d = snap ? '0 : win_cnt_q + CntWidth'(1);
    end
  end

  logic [NumStats-1:0][CntWidth-1:0] stat_amt, stat_sum_c, stat_d, stat_q;
  logic [NumStats-1:0]               stat_sat_c;
  logic [CntWidth-1:0]               wr_bytes_amt, rd_bytes_amt;

  always_comb begin
    wr_bytes_amt = '0;
    for (int unsigned i = 0; i < StrbWidth; i++) begin
      wr_bytes_amt = wr_bytes_amt + CntWidth'(axi_req_i.w.strb[i]);
    end
    rd_bytes_amt = (CntWidth'(axi_req_i.ar.len) + CntWidth'(1)) << axi_req_i.ar.size;

    stat_amt              = '0;
    stat_amt[STAT_AW]     = CntWidth'(aw_hs);
    stat_amt[STAT_AR]     = CntWidth'(ar_hs);
    stat_amt[STAT_W]      = CntWidth'(w_hs);
    stat_amt[STAT_R]      = CntWidth'(r_hs);
    stat_amt[STAT_WBYTES] = w_hs ? wr_bytes_amt : '0;
    stat_amt[STAT_RBYTES] = ar_hs ? rd_bytes_amt : '0;
    stat_amt[STAT_WLAT]   = CntWidth'(wr_outst_q);
    stat_amt[STAT_RLAT]   = CntWidth'(rd_outst_q);
  end

  for (genvar i = 0; i < NumStats; i++) begin : g_stat
    perf_sat_counter #(
      .Width(CntWidth)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .clear_i    (clear_i),
      .load_zero_i(snap),
      .amount_i   (stat_amt[i]),
      .sum_c      (stat_sum_c[i]),
      .sat_c      (stat_sat_c[i])
    );
  end

  logic snap_valid_d, snap_valid_q, overflow_d, overflow_q, proto_err_d, proto_err_q;

  // Visible outputs track live values in free-run, else only on a snapshot
  always_comb begin
    stat_d       = stat_q;
    snap_valid_d = snap;
    overflow_d   = overflow_q | (|stat_sat_c);
    proto_err_d  = proto_err_q | wr_err | rd_err;
    if (clear_i) begin
      stat_d      = '0;
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
    end else if (free_run || snap) begin
      stat_d = stat_sum_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_outst_q   <= '0;
      rd_outst_q   <= '0;
      win_len_q    <= '0;
      win_cnt_q    <= '0;
      stat_q       <= '0;
      snap_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      wr_outst_q   <= wr_outst_d;
      rd_outst_q   <= rd_outst_d;
      win_len_q    <= window_i;
      win_cnt_q    <= win_cnt_d;
      stat_q       <= stat_d;
      snap_valid_q <= snap_valid_d;
      overflow_q   <= overflow_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign aw_cnt_o     = stat_q[STAT_AW];
  assign ar_cnt_o     = stat_q[STAT_AR];
  assign w_beats_o    = stat_q[STAT_W];
  assign r_beats_o    = stat_q[STAT_R];
  assign wr_bytes_o   = stat_q[STAT_WBYTES];
  assign rd_bytes_o   = stat_q[STAT_RBYTES];
  assign wr_lat_sum_o = stat_q[STAT_WLAT];
  assign rd_lat_sum_o = stat_q[STAT_RLAT];
  assign wr_outst_o   = wr_outst_q;
  assign rd_outst_o   = rd_outst_q;
  assign snap_valid_o = snap_valid_q;
  assign overflow_o   = overflow_q;
  assign proto_err_o  = proto_err_q;

endmodule
